bcd_count_sequencer: RTL and testbench

Control sequencer for the bank of BCD digit counters behind the quad seven-segment display. It latches single-cycle increment/decrement/clear/fill requests from many sources and grants them one at a time through a round-robin arbiter. It drives each counter's up/down pulse and the shared set9/set0 lines. Carry/borrow ripple into higher digits runs as explicit sequenced steps rather than combinational chaining, with saturation at the top digit.

---
 rtl/bcd_seq_pkg.sv | 30 +++
 rtl/bcd_count_sequencer_rr_arbiter.sv | 47 ++++
 rtl/bcd_count_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_bcd_count_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_seq_pkg.sv
// Shared types and constants for the BCD counter sequencer.
// Build option BCD_SEQ_WRAP_EN is consumed by bcd_count_sequencer.sv.
package bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    SAT  = 2'd2
  } state_t;

  typedef enum logic {
    OP_UP   = 1'b0,
    OP_DOWN = 1'b1
  } op_t;

  localparam int DEFAULT_NUM_DIGITS = 32'sd4;

  // clr and fill sit just above the interleaved up/down bits
  function automatic int clr_idx(input int num_digits);
    return 32'sd2 * num_digits;
  endfunction

  function automatic int fill_idx(input int num_digits);
    return 32'sd2 * num_digits + 32'sd1;
  endfunction

  localparam int CLR_IDX  = clr_idx(DEFAULT_NUM_DIGITS);
  localparam int FILL_IDX = fill_idx(DEFAULT_NUM_DIGITS);

endpackage

// File: rtl/bcd_count_sequencer_rr_arbiter.sv
// Round-robin grant over the interleaved up/down pending bits.
// Grant is combinational; the search pointer is registered.
module rr_arbiter #(
  parameter int WIDTH = 32'sd8,
  parameter int IW    = (WIDTH > 32'sd1) ? $clog2(WIDTH) : 32'sd1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] req,
  input  logic             advance,
  output logic [WIDTH-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             grant_vld
);

  logic [IW-1:0] ptr_r;

  // Scan cyclically from the pointer; the first request found wins.
  always_comb begin
    int j;
    logic hit_s;
    grant_idx = '0;
    grant_vld = 1'b0;
    j         = 32'sd0;
    hit_s     = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      j         = int'(ptr_r) + i;
      j         = (j >= WIDTH) ? (j - WIDTH) : j;
      hit_s     = req[j] & ~grant_vld;
      grant_idx = hit_s ? IW'(j) : grant_idx;
      grant_vld = grant_vld | req[j];
    end
    grant = grant_vld ? (WIDTH'(1'b1) << grant_idx) : '0;
  end

  // Pointer moves past the granted bit only when the caller consumes the grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (advance && grant_vld) begin
      ptr_r <= (int'(grant_idx) == WIDTH - 32'sd1) ? '0 : grant_idx + IW'(1'b1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/bcd_count_sequencer.sv
// Sequencer for the BCD digit counters: latches requests, grants them one at a time,
// and ripples carry/borrow digit by digit. Define BCD_SEQ_WRAP_EN to wrap instead of saturate.
module bcd_count_sequencer
  import bcd_seq_pkg::*;
#(
  parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_DIGITS-1:0] req_up,
  input  logic [NUM_DIGITS-1:0] req_down,
  input  logic                  req_clr,
  input  logic                  req_fill,
  input  logic [NUM_DIGITS-1:0] cnt_cout,
  input  logic [NUM_DIGITS-1:0] cnt_bout,
  output logic [NUM_DIGITS-1:0] cnt_up,
  output logic [NUM_DIGITS-1:0] cnt_down,
  output logic                  cnt_set9,
  output logic                  cnt_set0,
  output logic                  busy,
  output logic                  ovf,
  output logic                  unf,
  output logic                  drop
);

  localparam int RR_W   = 32'sd2 * NUM_DIGITS;
  localparam int PEND_W = RR_W + 32'sd2;
  localparam int CLR_B  = clr_idx(NUM_DIGITS);
  localparam int FILL_B = fill_idx(NUM_DIGITS);
  localparam int IW     = $clog2(RR_W);
  localparam int DW     = (NUM_DIGITS > 32'sd1) ? $clog2(NUM_DIGITS) : 32'sd1;
  localparam logic [DW-1:0] TOP_DIG = DW'(NUM_DIGITS - 32'sd1);

  state_t                state_r;
  op_t                   op_r;
  logic [DW-1:0]         dig_r;
  logic [PEND_W-1:0]     pend_r;
  logic                  ovf_r;
  logic                  unf_r;
  logic                  drop_r;
  logic [NUM_DIGITS-1:0] cnt_up_r;
  logic [NUM_DIGITS-1:0] cnt_down_r;
  logic                  set9_r;
  logic                  set0_r;

  logic [PEND_W-1:0]     req_vec_s;
  logic [PEND_W-1:0]     gnt_clr_s;
  logic [PEND_W-1:0]     pend_nxt_s;
  logic [RR_W-1:0]       rr_grant_s;
  logic [IW-1:0]         rr_idx_s;
  logic                  rr_vld_s;
  logic                  rr_adv_s;
  logic [DW-1:0]         gnt_dig_s;
  op_t                   gnt_op_s;
  logic [DW-1:0]         dig_inc_s;
  logic                  carry_s;

  rr_arbiter #(
    .WIDTH (RR_W),
    .IW    (IW)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .req       (pend_r[RR_W-1:0]),
    .advance   (rr_adv_s),
    .grant     (rr_grant_s),
    .grant_idx (rr_idx_s),
    .grant_vld (rr_vld_s)
  );

  assign gnt_dig_s = DW'(rr_idx_s >> 1);
  assign gnt_op_s  = op_t'(rr_idx_s[0]);
  assign dig_inc_s = dig_r + DW'(1'b1);
  assign carry_s   = (op_r == OP_UP) ? cnt_cout[dig_r] : cnt_bout[dig_r];

  // Interleave the request lines into pending-bit order.
  always_comb begin
    req_vec_s = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      req_vec_s[2*k]   = req_up[k];
      req_vec_s[2*k+1] = req_down[k];
    end
    req_vec_s[CLR_B]  = req_clr;
    req_vec_s[FILL_B] = req_fill;
  end

  // Bit consumed by the IDLE-state selection: clr, then fill, then round-robin.
  always_comb begin
    gnt_clr_s = '0;
    rr_adv_s  = 1'b0;
    if (state_r == IDLE) begin
      if (pend_r[CLR_B]) begin
        gnt_clr_s[CLR_B] = 1'b1;
      end else if (pend_r[FILL_B]) begin
        gnt_clr_s[FILL_B] = 1'b1;
      end else begin
        gnt_clr_s[RR_W-1:0] = rr_grant_s;
        rr_adv_s            = rr_vld_s;
      end
    end else begin
      gnt_clr_s = '0;
      rr_adv_s  = 1'b0;
    end
  end

  // Opposing up/down on one digit annihilate before they are ever stored together.
  always_comb begin
    pend_nxt_s = (pend_r & ~gnt_clr_s) | req_vec_s;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      pend_nxt_s[2*k+:2] = (&pend_nxt_s[2*k+:2]) ? 2'b00 : pend_nxt_s[2*k+:2];
    end
  end

  // Pending register and coalesce indicator; a bit granted this cycle may be re-armed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_r <= '0;
      drop_r <= 1'b0;
    end else begin
      pend_r <= pend_nxt_s;
      drop_r <= |(req_vec_s & pend_r & ~gnt_clr_s);
    end
  end

  // Sequencer FSM with registered counter strobes and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      op_r       <= OP_UP;
      dig_r      <= '0;
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
      cnt_up_r   <= '0;
      cnt_down_r <= '0;
      set9_r     <= 1'b0;
      set0_r     <= 1'b0;
    end else begin
      cnt_up_r   <= '0;
      cnt_down_r <= '0;
      set9_r     <= 1'b0;
      set0_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pend_r[CLR_B]) begin
            state_r <= SAT;
            set0_r  <= 1'b1;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
          end else if (pend_r[FILL_B]) begin
            state_r <= SAT;
            set9_r  <= 1'b1;
          end else if (rr_vld_s) begin
            state_r <= STEP;
            op_r    <= gnt_op_s;
            dig_r   <= gnt_dig_s;
            if (gnt_op_s == OP_UP) begin
              cnt_up_r[gnt_dig_s] <= 1'b1;
            end else begin
              cnt_down_r[gnt_dig_s] <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        STEP: begin
          if (!carry_s) begin
            state_r <= IDLE;
          end else if (dig_r != TOP_DIG) begin
            dig_r <= dig_inc_s;
            if (op_r == OP_UP) begin
              cnt_up_r[dig_inc_s] <= 1'b1;
            end else begin
              cnt_down_r[dig_inc_s] <= 1'b1;
            end
          end else begin
            if (op_r == OP_UP) begin
              ovf_r <= 1'b1;
            end else begin
              unf_r <= 1'b1;
            end
`ifdef BCD_SEQ_WRAP_EN
            state_r <= IDLE;
`else
            state_r <= SAT;
            if (op_r == OP_UP) begin
              set9_r <= 1'b1;
            end else begin
              set0_r <= 1'b1;
            end
`endif
          end
        end
        SAT: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign cnt_up   = cnt_up_r;
  assign cnt_down = cnt_down_r;
  assign cnt_set9 = set9_r;
  assign cnt_set0 = set0_r;
  assign ovf      = ovf_r;
  assign unf      = unf_r;
  assign drop     = drop_r;
  assign busy     = (state_r != IDLE) || (|pend_r);

endmodule

// File: tb/tb_bcd_count_sequencer.sv
// Directed bench for bcd_count_sequencer with a four-digit BCD counter bank model.
module tb_bcd_count_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] req_up;
  logic [3:0] req_down;
  logic       req_clr;
  logic       req_fill;
  logic [3:0] cnt_cout;
  logic [3:0] cnt_bout;
  logic [3:0] cnt_up;
  logic [3:0] cnt_down;
  logic       cnt_set9;
  logic       cnt_set0;
  logic       busy;
  logic       ovf;
  logic       unf;
  logic       drop;

  logic        load_en;
  logic [15:0] load_val;
  logic [15:0] disp;
  logic [13:0] out_w;

  int checks = 0;
  int errors = 0;

  bcd_count_sequencer #(.NUM_DIGITS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_up   (req_up),
    .req_down (req_down),
    .req_clr  (req_clr),
    .req_fill (req_fill),
    .cnt_cout (cnt_cout),
    .cnt_bout (cnt_bout),
    .cnt_up   (cnt_up),
    .cnt_down (cnt_down),
    .cnt_set9 (cnt_set9),
    .cnt_set0 (cnt_set0),
    .busy     (busy),
    .ovf      (ovf),
    .unf      (unf),
    .drop     (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // layout: busy ovf unf drop set9 set0 down[3:0] up[3:0]
  assign out_w = {busy, ovf, unf, drop, cnt_set9, cnt_set0, cnt_down, cnt_up};

  // Counter bank: combinational carry/borrow, state updated on the clock.
  always_comb begin
    cnt_cout = 4'b0000;
    cnt_bout = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      cnt_cout[k] = cnt_up[k] && (disp[4*k+:4] == 4'd9);
      cnt_bout[k] = cnt_down[k] && (disp[4*k+:4] == 4'd0);
    end
  end

  always @(posedge clk) begin
    if (load_en) disp <= load_val;
    else if (cnt_set9) disp <= 16'h9999;
    else if (cnt_set0) disp <= 16'h0000;
    else begin
      for (int k = 0; k < 4; k++) begin
        if (cnt_up[k]) disp[4*k+:4] <= (disp[4*k+:4] == 4'd9) ? 4'd0 : disp[4*k+:4] + 4'd1;
        else if (cnt_down[k]) disp[4*k+:4] <= (disp[4*k+:4] == 4'd0) ? 4'd9 : disp[4*k+:4] - 4'd1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [13:0] exp);
    checks++;
    assert (out_w === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, out_w, exp);
    end
  endtask

  task automatic check_disp(input string tag, input logic [15:0] exp);
    checks++;
    assert (disp === exp) else begin
      errors++;
      $error("FAIL %s: display observed %h expected %h", tag, disp, exp);
    end
  endtask

  task automatic do_clr(input string tag, input logic [13:0] exp_c1);
    req_clr = 1'b1;
    tick;
    req_clr = 1'b0;
    check({tag, "_c1"}, exp_c1);
    tick; check({tag, "_set0"}, 14'b1_0_0_0_0_1_0000_0000);
    tick; check({tag, "_idle"}, 14'b0_0_0_0_0_0_0000_0000);
    check_disp({tag, "_disp"}, 16'h0000);
  endtask

  initial begin
    reset    = 1'b1;
    req_up   = 4'b0000;
    req_down = 4'b0000;
    req_clr  = 1'b0;
    req_fill = 1'b0;
    load_en  = 1'b1;
    load_val = 16'h0000;
    tick;
    tick;
    check("reset_state", 14'b0);
    load_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick;

    // fill + up[1] + down[3] together: set9 first, then up[1] before down[3]
    req_up = 4'b0010; req_down = 4'b1000; req_fill = 1'b1;
    tick;
    req_up = 4'b0000; req_down = 4'b0000; req_fill = 1'b0;
    check("mix_c1", 14'b1_0_0_0_0_0_0000_0000);
    tick; check("mix_set9", 14'b1_0_0_0_1_0_0000_0000);
    tick; check("mix_c3", 14'b1_0_0_0_0_0_0000_0000);
    tick; check("mix_up1", 14'b1_0_0_0_0_0_0000_0010);
    tick; check("mix_up2", 14'b1_0_0_0_0_0_0000_0100);
    tick; check("mix_up3", 14'b1_0_0_0_0_0_0000_1000);
`ifndef BCD_SEQ_WRAP_EN
    tick; check("mix_sat9", 14'b1_1_0_0_1_0_0000_0000);
    tick; check("mix_c8", 14'b1_1_0_0_0_0_0000_0000);
    tick; check("mix_dn3", 14'b1_1_0_0_0_0_1000_0000);
    tick; check("mix_idle", 14'b0_1_0_0_0_0_0000_0000);
    check_disp("mix_disp", 16'h8999);
    do_clr("clr_a", 14'b1_1_0_0_0_0_0000_0000);
`else
    tick; check("mix_c7", 14'b1_1_0_0_0_0_0000_0000);
    tick; check("mix_dn3", 14'b1_1_0_0_0_0_1000_0000);
    tick; check("mix_idle", 14'b0_1_1_0_0_0_0000_0000);
    check_disp("mix_disp", 16'h9009);
    do_clr("clr_a", 14'b1_1_1_0_0_0_0000_0000);
`endif

    // 0999 + 1 ripples through digits 0..3
    load_en = 1'b1; load_val = 16'h0999;
    tick;
    load_en = 1'b0;
    req_up = 4'b0001;
    tick;
    req_up = 4'b0000;
    check("r1_c1", 14'b1_0_0_0_0_0_0000_0000);
    tick; check("r1_up0", 14'b1_0_0_0_0_0_0000_0001);
    tick; check("r1_up1", 14'b1_0_0_0_0_0_0000_0010);
    tick; check("r1_up2", 14'b1_0_0_0_0_0_0000_0100);
    tick; check("r1_up3", 14'b1_0_0_0_0_0_0000_1000);
    tick; check("r1_idle", 14'b0_0_0_0_0_0_0000_0000);
    check_disp("r1_disp", 16'h1000);

    // 9999 + 1 overflows the top digit
    load_en = 1'b1; load_val = 16'h9999;
    tick;
    load_en = 1'b0;
    req_up = 4'b0001;
    tick;
    req_up = 4'b0000;
    check("ov_c1", 14'b1_0_0_0_0_0_0000_0000);
    tick; check("ov_up0", 14'b1_0_0_0_0_0_0000_0001);
    tick; check("ov_up1", 14'b1_0_0_0_0_0_0000_0010);
    tick; check("ov_up2", 14'b1_0_0_0_0_0_0000_0100);
    tick; check("ov_up3", 14'b1_0_0_0_0_0_0000_1000);
`ifndef BCD_SEQ_WRAP_EN
    tick; check("ov_set9", 14'b1_1_0_0_1_0_0000_0000);
    tick; check("ov_idle", 14'b0_1_0_0_0_0_0000_0000);
    check_disp("ov_disp", 16'h9999);
`else
    tick; check("ov_wrap", 14'b0_1_0_0_0_0_0000_0000);
    check_disp("ov_disp", 16'h0000);
    tick; check("ov_idle", 14'b0_1_0_0_0_0_0000_0000);
`endif
    do_clr("clr_b", 14'b1_1_0_0_0_0_0000_0000);

    // 0000, down on digit 2 borrows out of the top digit
    req_down = 4'b0100;
    tick;
    req_down = 4'b0000;
    check("un_c1", 14'b1_0_0_0_0_0_0000_0000);
    tick; check("un_dn2", 14'b1_0_0_0_0_0_0100_0000);
    tick; check("un_dn3", 14'b1_0_0_0_0_0_1000_0000);
`ifndef BCD_SEQ_WRAP_EN
    tick; check("un_set0", 14'b1_0_1_0_0_1_0000_0000);
    tick; check("un_idle", 14'b0_0_1_0_0_0_0000_0000);
    check_disp("un_disp", 16'h0000);
`else
    tick; check("un_wrap", 14'b0_0_1_0_0_0_0000_0000);
    check_disp("un_disp", 16'h9900);
    tick; check("un_idle", 14'b0_0_1_0_0_0_0000_0000);
`endif
    do_clr("clr_c", 14'b1_0_1_0_0_0_0000_0000);

    // opposing requests on one digit cancel
    req_up = 4'b0001; req_down = 4'b0001;
    tick;
    req_up = 4'b0000; req_down = 4'b0000;
    check("nz_c1", 14'b0);
    tick; check("nz_c2", 14'b0);
    tick; check("nz_c3", 14'b0);
    check_disp("nz_disp", 16'h0000);

    // repeat up[2] while it waits behind clr: coalesced, drop pulses
    req_clr = 1'b1; req_up = 4'b0100;
    tick;
    req_clr = 1'b0;
    check("dr_c1", 14'b1_0_0_0_0_0_0000_0000);
    tick;
    req_up = 4'b0000;
    check("dr_set0", 14'b1_0_0_1_0_1_0000_0000);
    tick; check("dr_c3", 14'b1_0_0_0_0_0_0000_0000);
    tick; check("dr_up2", 14'b1_0_0_0_0_0_0000_0100);
    tick; check("dr_c5", 14'b0);
    tick; check("dr_c6", 14'b0);
    check_disp("dr_disp", 16'h0100);

    // reset in the middle of a 9999 ripple
    load_en = 1'b1; load_val = 16'h9999;
    tick;
    load_en = 1'b0;
    req_up = 4'b0001;
    tick;
    req_up = 4'b0000;
    check("rs_c1", 14'b1_0_0_0_0_0_0000_0000);
    tick; check("rs_up0", 14'b1_0_0_0_0_0_0000_0001);
    tick; check("rs_up1", 14'b1_0_0_0_0_0_0000_0010);
    tick; check("rs_up2", 14'b1_0_0_0_0_0_0000_0100);
    #2;
    reset = 1'b1;
    #1;
    check("rs_async", 14'b0);
    tick; check("rs_hold", 14'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("rs_after", 14'b0);
    end
    check_disp("rs_disp", 16'h9900);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
